// File: rtl/reset_sequencer.sv
// Ordered reset-release controller: holds every domain in reset, then releases them one by one,
// each after the previous domain's ready ack plus a fixed gap. RESET_SEQ_TIMEOUT_EN adds a ready-wait timeout.
module reset_sequencer #(
  parameter int N    = 4,
  parameter int HOLD = 16,
  parameter int GAP  = 4,
  parameter int TMO  = 1024,
  localparam int EW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic [N-1:0]  dom_ready,
  output logic [N-1:0]  dom_reset,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [EW-1:0] err_dom
);

  localparam int HG_MAX = (HOLD > GAP) ? HOLD : GAP;
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int CNT_MAX = (HG_MAX > TMO) ? HG_MAX : TMO;
`else
  localparam int CNT_MAX = HG_MAX;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  if (N < 1 || HOLD < 1 || GAP < 1 || TMO < 1) begin : g_bad_param
    $error("reset_sequencer: N, HOLD, GAP and TMO must all be at least 1");
  end

  typedef enum logic [2:0] {ST_ASSERT, ST_WAIT, ST_GAP, ST_DONE, ST_ERROR} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [EW-1:0]   idx_reg, idx_next;
  logic [N-1:0]    dom_reset_reg, dom_reset_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            err_next;
  logic [EW-1:0]   err_dom_next;

  logic [N-1:0]    ready_sel;
  logic [N-1:0]    next_hot;
  logic [EW-1:0]   idx_inc;
  logic            ready_cur;

  // Ready of the domain currently being waited on, and a one-hot of the next domain to release
  assign idx_inc = idx_reg + EW'(1);
  for (genvar gi = 0; gi < N; gi++) begin : g_sel
    assign ready_sel[gi] = dom_ready[gi] && (idx_reg == EW'(gi));
    assign next_hot[gi]  = (idx_inc == EW'(gi));
  end
  assign ready_cur = |ready_sel;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    dom_reset_next = dom_reset_reg;
    busy_next      = busy_reg;
    done_next      = done_reg;
    err_next       = err;
    err_dom_next   = err_dom;
    case (state_reg)
      ST_ASSERT: begin
        dom_reset_next = '1;
        if (cnt_reg == CW'(HOLD - 1)) begin
          dom_reset_next[0] = 1'b0;
          idx_next          = '0;
          cnt_next          = '0;
          state_next        = ST_WAIT;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_WAIT: begin
        if (ready_cur) begin
          if (idx_reg == EW'(N - 1)) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end else begin
            state_next = ST_GAP;
            cnt_next   = '0;
          end
        end else begin
`ifdef RESET_SEQ_TIMEOUT_EN
          if (cnt_reg == CW'(TMO - 1)) begin
            state_next   = ST_ERROR;
            err_next     = 1'b1;
            err_dom_next = idx_reg;
            busy_next    = 1'b0;
            done_next    = 1'b0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
`endif
        end
      end
      ST_GAP: begin
        if (cnt_reg == CW'(GAP - 1)) begin
          idx_next       = idx_inc;
          dom_reset_next = dom_reset_reg & ~next_hot;
          cnt_next       = '0;
          state_next     = ST_WAIT;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: ;  // DONE and ERROR hold until req
    endcase

    // A restart request overrides whatever the state machine decided this cycle
    if (req) begin
      state_next     = ST_ASSERT;
      cnt_next       = '0;
      idx_next       = '0;
      dom_reset_next = '1;
      busy_next      = 1'b1;
      done_next      = 1'b0;
      err_next       = 1'b0;
      err_dom_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_ASSERT;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      dom_reset_reg <= '1;
      busy_reg      <= 1'b1;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      dom_reset_reg <= dom_reset_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  logic          err_reg;
  logic [EW-1:0] err_dom_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_reg     <= 1'b0;
      err_dom_reg <= '0;
    end else begin
      err_reg     <= err_next;
      err_dom_reg <= err_dom_next;
    end
  end

  assign err     = err_reg;
  assign err_dom = err_dom_reg;
`else
  // Without the timeout the error outputs are tied off; the next-values are simply dropped
  logic unused_err;
  assign unused_err = err_next ^ (^err_dom_next);
  assign err        = 1'b0;
  assign err_dom    = '0;
`endif

  assign dom_reset = dom_reset_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: an edge-timestamp model plus directed literal checks.
// The timeout scenario runs only when RESET_SEQ_TIMEOUT_EN is defined.
module tb_reset_sequencer;

  localparam int N    = 4;
  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int TMO  = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req;
  logic [N-1:0] dom_ready;
  logic [N-1:0] dom_reset;
  logic         busy, done, err;
  logic [1:0]   err_dom;

  logic [0:0]   dom_ready1;
  logic         req1;
  logic [0:0]   dom_reset1;
  logic         busy1, done1, err1;
  logic [0:0]   err_dom1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.N(N), .HOLD(HOLD), .GAP(GAP), .TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .dom_ready(dom_ready),
    .dom_reset(dom_reset), .busy(busy), .done(done), .err(err), .err_dom(err_dom)
  );

  reset_sequencer #(.N(1), .HOLD(1), .GAP(1), .TMO(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req1), .dom_ready(dom_ready1),
    .dom_reset(dom_reset1), .busy(busy1), .done(done1), .err(err1), .err_dom(err_dom1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: tracks how many domains are released and the edge number at which the next release is due
  int m_now, m_due, m_rel, m_wcnt, m_err_dom;
  bit m_wait, m_done, m_err;
  logic [N-1:0] exp_reset;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_now <= 0; m_due <= HOLD; m_rel <= 0; m_wcnt <= 0;
      m_wait <= 0; m_done <= 0; m_err <= 0; m_err_dom <= 0;
    end else begin
      m_now <= m_now + 1;
      if (req) begin
        m_rel <= 0; m_due <= m_now + 1 + HOLD; m_wait <= 0;
        m_done <= 0; m_err <= 0; m_err_dom <= 0;
      end else if (m_done || m_err) begin
        m_rel <= m_rel;
      end else if (!m_wait) begin
        if (m_now + 1 == m_due) begin
          m_rel <= m_rel + 1; m_wait <= 1; m_wcnt <= 0;
        end
      end else if (dom_ready[m_rel-1]) begin
        m_wait <= 0;
        if (m_rel == N) m_done <= 1;
        else m_due <= m_now + 1 + GAP;
      end else begin
`ifdef RESET_SEQ_TIMEOUT_EN
        if (m_wcnt == TMO - 1) begin
          m_err <= 1; m_err_dom <= m_rel - 1;
        end else begin
          m_wcnt <= m_wcnt + 1;
        end
`endif
      end
    end
  end

  always_comb exp_reset = {N{1'b1}} << m_rel;

  always @(negedge clk) begin
    chk("m_dom_reset", dom_reset, exp_reset);
    chk("m_busy", busy, !m_done && !m_err);
    chk("m_done", done, m_done);
    chk("m_err", err, m_err);
    chk("m_err_dom", err_dom, m_err_dom);
  end

  initial begin
    reset_n = 1'b0; req = 1'b0; dom_ready = 4'hF; req1 = 1'b0; dom_ready1 = 1'b1;
    edges(2);
    chk("rst_dom_reset", dom_reset, 4'hF);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("n1_rst_dom_reset", dom_reset1, 1);

    // Scenario 1: all ready, releases after edges 16/21/26/31, done after 32; N=1 instance alongside
    reset_n = 1'b1;
    edges(1);
    chk("n1_release_e1", dom_reset1, 0);
    chk("n1_done_e1", done1, 0);
    edges(1);
    chk("n1_done_e2", done1, 1);
    chk("n1_busy_e2", busy1, 0);
    edges(13);
    chk("s1_e15", dom_reset, 4'hF);
    edges(1);
    chk("s1_e16", dom_reset, 4'hE);
    edges(5);
    chk("s1_e21", dom_reset, 4'hC);
    edges(5);
    chk("s1_e26", dom_reset, 4'h8);
    edges(5);
    chk("s1_e31", dom_reset, 4'h0);
    chk("s1_done_e31", done, 0);
    edges(1);
    chk("s1_done_e32", done, 1);
    chk("s1_busy_e32", busy, 0);

    // Scenario 2: domain 1 acks late; domain 2 released GAP edges after the ready edge
    dom_ready = 4'b1101; req = 1'b1;
    edges(1);
    chk("s2_req_dom_reset", dom_reset, 4'hF);
    chk("s2_req_done", done, 0);
    req = 1'b0;
    edges(21);
    chk("s2_d1_released", dom_reset, 4'hC);
    edges(10);
    chk("s2_still_waiting", dom_reset, 4'hC);
    chk("s2_busy", busy, 1);
    dom_ready = 4'hF;
    edges(4);
    chk("s2_ready_plus3", dom_reset, 4'hC);
    edges(1);
    chk("s2_ready_plus4", dom_reset, 4'h8);

    // Scenario 3: req pulse while in the gap after domain 1; full re-run from req low
    req = 1'b1;
    edges(1);
    req = 1'b0;
    edges(22);
    chk("s3_d1_released", dom_reset, 4'hC);
    req = 1'b1;
    edges(1);
    chk("s3_req_dom_reset", dom_reset, 4'hF);
    chk("s3_req_busy", busy, 1);
    req = 1'b0;
    edges(31);
    chk("s3_done_r31", done, 0);
    edges(1);
    chk("s3_done_r32", done, 1);

    // Scenario 4: async reset while waiting on domain 3
    dom_ready = 4'b0111; req = 1'b1;
    edges(1);
    req = 1'b0;
    edges(33);
    chk("s4_wait_d3", dom_reset, 4'h0);
    chk("s4_wait_done", done, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("s4_async_dom_reset", dom_reset, 4'hF);
    chk("s4_async_busy", busy, 1);
    chk("s4_async_done", done, 0);
    reset_n = 1'b1; dom_ready = 4'hF;
    edges(1);
    chk("s4_n1_release", dom_reset1, 0);
    edges(15);
    chk("s4_e16", dom_reset, 4'hE);
    edges(16);
    chk("s4_done_e32", done, 1);

`ifdef RESET_SEQ_TIMEOUT_EN
    // Scenario 5: domain 2 never acks; error after the 8th WAIT edge, then req clears it
    dom_ready = 4'b1011; req = 1'b1;
    edges(1);
    req = 1'b0;
    edges(33);
    chk("s5_err_r33", err, 0);
    edges(1);
    chk("s5_err_r34", err, 1);
    chk("s5_err_dom", err_dom, 2);
    chk("s5_err_dom_reset", dom_reset, 4'h8);
    chk("s5_err_busy", busy, 0);
    chk("s5_err_done", done, 0);
    req = 1'b1;
    edges(1);
    chk("s5_req_err", err, 0);
    chk("s5_req_dom_reset", dom_reset, 4'hF);
    req = 1'b0; dom_ready = 4'hF;
    edges(32);
    chk("s5_done", done, 1);
`endif

    edges(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
